// File: rtl/multi_channel_pulse_gen.sv
// N_CH independent periodic/one-shot pulse channels sharing one tick prescaler.
// pulse_o/busy_o are registered (one edge after the deciding sample); no backpressure.
module multi_channel_pulse_gen #(
  parameter int N_CH     = 4,
  parameter int CNT_W    = 27,
  parameter int PRESCALE = 1,
  parameter int PULSE_W  = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [N_CH-1:0]         en_i,
  input  logic [N_CH-1:0]         mode_i,
  input  logic [N_CH-1:0]         start_i,
  input  logic [N_CH*CNT_W-1:0]   period_i,
  output logic [N_CH-1:0]         pulse_o,
  output logic [N_CH-1:0]         busy_o
);

  localparam int SW = $clog2(PULSE_W + 1);
  localparam logic [SW-1:0] STR_RELOAD = SW'(PULSE_W - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  logic tick;

  generate
    if (PRESCALE == 1) begin : g_no_prescale
      assign tick = 1'b1;
    end else begin : g_prescale
      localparam int PS_W = $clog2(PRESCALE);
      localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

      logic [PS_W-1:0] ps_q;
      logic [PS_W-1:0] ps_d;

      assign tick = (ps_q == PS_LAST);
      assign ps_d = tick ? '0 : ps_q + PS_W'(1);

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          ps_q <= '0;
        end else begin
          ps_q <= ps_d;
        end
      end
    end
  endgenerate

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] plat_q, plat_d;
    logic             mlat_q, mlat_d;
    logic [SW-1:0]    str_q, str_d;
    logic             pulse_q, pulse_d;
    logic [CNT_W-1:0] period_sel;

    assign period_sel = period_i[i*CNT_W +: CNT_W];

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      plat_d  = plat_q;
      mlat_d  = mlat_q;
      str_d   = str_q;
      pulse_d = 1'b0;

      if (str_q != '0) begin
        str_d   = str_q - SW'(1);
        pulse_d = 1'b1;
      end

      // Disable wins over entry, fire and any stretch in progress.
      if (!en_i[i]) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        str_d   = '0;
        pulse_d = 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (!mode_i[i] || start_i[i]) begin
              state_d = ST_RUN;
              cnt_d   = '0;
              plat_d  = period_sel;
              mlat_d  = mode_i[i];
            end
          end
          ST_RUN: begin
            if (tick) begin
              if (cnt_q == plat_q) begin
                pulse_d = 1'b1;
                str_d   = STR_RELOAD;
                cnt_d   = '0;
                plat_d  = period_sel;
                mlat_d  = mode_i[i];
                if (mlat_q) begin
                  state_d = ST_IDLE;
                end
              end else begin
                cnt_d = cnt_q + CNT_W'(1);
              end
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        plat_q  <= '0;
        mlat_q  <= 1'b0;
        str_q   <= '0;
        pulse_q <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        plat_q  <= plat_d;
        mlat_q  <= mlat_d;
        str_q   <= str_d;
        pulse_q <= pulse_d;
      end
    end

    assign pulse_o[i] = pulse_q;
    assign busy_o[i]  = (state_q == ST_RUN);
  end

endmodule

// File: tb/tb_multi_channel_pulse_gen.sv
// Bench for multi_channel_pulse_gen: three instances (4ch/PS1/PW1, 1ch/PS4/PW3, 1ch/PS1/PW4)
// viewed as six lanes, checked every cycle against a schedule-based model plus literal points.
`timescale 1ns/1ps
module tb_multi_channel_pulse_gen;

  localparam int NL = 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [NL-1:0] en_l    = '0;
  logic [NL-1:0] mode_l  = '0;
  logic [NL-1:0] start_l = '0;
  logic [26:0]   per_l [NL];

  logic [3:0] p0, b0;
  logic       p1, b1, p2, b2;
  logic [NL-1:0] pulse_l, busy_l;
  assign pulse_l = {p2, p1, p0};
  assign busy_l  = {b2, b1, b0};

  multi_channel_pulse_gen #(.N_CH(4), .CNT_W(27), .PRESCALE(1), .PULSE_W(1)) u_quad (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en_l[3:0]), .mode_i(mode_l[3:0]),
    .start_i(start_l[3:0]), .period_i({per_l[3], per_l[2], per_l[1], per_l[0]}),
    .pulse_o(p0), .busy_o(b0));

  multi_channel_pulse_gen #(.N_CH(1), .CNT_W(8), .PRESCALE(4), .PULSE_W(3)) u_ps4 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en_l[4]), .mode_i(mode_l[4]),
    .start_i(start_l[4]), .period_i(per_l[4][7:0]),
    .pulse_o(p1), .busy_o(b1));

  multi_channel_pulse_gen #(.N_CH(1), .CNT_W(8), .PRESCALE(1), .PULSE_W(4)) u_pw4 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en_l[5]), .mode_i(mode_l[5]),
    .start_i(start_l[5]), .period_i(per_l[5][7:0]),
    .pulse_o(p2), .busy_o(b2));

  function automatic int ps_of(int l);
    return (l == 4) ? 4 : 1;
  endfunction

  function automatic int pw_of(int l);
    return (l == 4) ? 3 : ((l == 5) ? 4 : 1);
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, int lane, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s lane %0d: got %0d, expected %0d at %0t", name, lane, act, exp, $time);
    end
  endtask

  // Model: fires are scheduled by tick index (ticks among edges 0..k = (k+1)/PRESCALE),
  // and the pulse is high while fewer than PULSE_W edges have passed since the last fire.
  int            k;
  bit            m_act  [NL];
  bit            m_lm   [NL];
  int            m_due  [NL];
  int            m_last [NL];
  logic [NL-1:0] exp_pulse = '0;
  logic [NL-1:0] exp_busy  = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k = 0;
      for (int l = 0; l < NL; l++) begin
        m_act[l]  = 1'b0;
        m_lm[l]   = 1'b0;
        m_due[l]  = 0;
        m_last[l] = -100000;
      end
      exp_pulse = '0;
      exp_busy  = '0;
    end else begin
      for (int l = 0; l < NL; l++) begin
        int ps;
        int nt;
        bit tk;
        ps = ps_of(l);
        tk = ((k % ps) == ps - 1);
        nt = (k + 1) / ps;
        if (!en_l[l]) begin
          m_act[l]  = 1'b0;
          m_last[l] = -100000;
        end else if (!m_act[l]) begin
          if (!mode_l[l] || start_l[l]) begin
            m_act[l] = 1'b1;
            m_lm[l]  = mode_l[l];
            m_due[l] = nt + int'(per_l[l]) + 1;
          end
        end else if (tk && nt == m_due[l]) begin
          m_last[l] = k;
          if (m_lm[l]) m_act[l] = 1'b0;
          m_lm[l]  = mode_l[l];
          m_due[l] = nt + int'(per_l[l]) + 1;
        end
        exp_busy[l]  = m_act[l];
        exp_pulse[l] = ((k - m_last[l]) < pw_of(l));
      end
      k++;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int l = 0; l < NL; l++) begin
        chk("model_pulse", l, int'(pulse_l[l]), int'(exp_pulse[l]));
        chk("model_busy", l, int'(busy_l[l]), int'(exp_busy[l]));
      end
    end
  end

  task automatic nx(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int cnt3, cnt5, w;
    for (int l = 0; l < NL; l++) per_l[l] = '0;
    #1 rst_n = 1'b0;
    nx(2);
    chk("reset_pulse", -1, int'(pulse_l), 0);
    chk("reset_busy", -1, int'(busy_l), 0);
    rst_n = 1'b1;
    nx(1);

    // Lanes 0/1 periodic P=3; lane 1 switches to P=1 before edge 2.
    per_l[0] = 27'd3;
    per_l[1] = 27'd3;
    en_l[1:0] = 2'b11;
    nx(1);
    chk("per_busy_e0", 0, int'(busy_l[0]), 1);
    chk("per_pulse_e0", 0, int'(pulse_l[0]), 0);
    nx(1);
    per_l[1] = 27'd1;
    nx(3);
    chk("per_pulse_e4", 0, int'(pulse_l[0]), 1);
    chk("chg_pulse_e4", 1, int'(pulse_l[1]), 1);
    nx(1);
    chk("per_pulse_e5", 0, int'(pulse_l[0]), 0);
    chk("chg_pulse_e5", 1, int'(pulse_l[1]), 0);
    nx(1);
    chk("per_pulse_e6", 0, int'(pulse_l[0]), 0);
    chk("chg_pulse_e6", 1, int'(pulse_l[1]), 1);
    nx(2);
    chk("per_pulse_e8", 0, int'(pulse_l[0]), 1);
    chk("chg_pulse_e8", 1, int'(pulse_l[1]), 1);
    en_l[1:0] = 2'b00;
    nx(1);
    chk("dis_busy", 0, int'(busy_l[1:0]), 0);

    // Lane 2 one-shot P=5, second start two edges later is ignored.
    per_l[2]   = 27'd5;
    mode_l[2]  = 1'b1;
    en_l[2]    = 1'b1;
    start_l[2] = 1'b1;
    nx(1);
    start_l[2] = 1'b0;
    chk("os_busy_s0", 2, int'(busy_l[2]), 1);
    nx(1);
    start_l[2] = 1'b1;
    nx(1);
    start_l[2] = 1'b0;
    nx(3);
    chk("os_busy_s5", 2, int'(busy_l[2]), 1);
    chk("os_pulse_s5", 2, int'(pulse_l[2]), 0);
    nx(1);
    chk("os_pulse_s6", 2, int'(pulse_l[2]), 1);
    chk("os_busy_s6", 2, int'(busy_l[2]), 0);
    nx(1);
    chk("os_pulse_s7", 2, int'(pulse_l[2]), 0);
    en_l[2]   = 1'b0;
    mode_l[2] = 1'b0;

    // Lane 4: PRESCALE=4, PULSE_W=3, P=2 -> 3 high of every 12.
    per_l[4] = 27'd2;
    en_l[4]  = 1'b1;
    nx(16);
    cnt3 = 0;
    repeat (24) begin
      nx(1);
      if (pulse_l[4]) cnt3++;
    end
    chk("ps4_duty", 4, cnt3, 6);
    w = 0;
    while (pulse_l[4] && w < 20) begin nx(1); w++; end
    while (!pulse_l[4] && w < 40) begin nx(1); w++; end
    chk("ps4_found_rise", 4, int'(pulse_l[4]), 1);
    en_l[4] = 1'b0;
    nx(1);
    chk("ps4_dis_pulse", 4, int'(pulse_l[4]), 0);
    chk("ps4_dis_busy", 4, int'(busy_l[4]), 0);

    // Lane 5 PW=4 P=1 and lane 3 P=0: both stay high continuously.
    per_l[5] = 27'd1;
    per_l[3] = 27'd0;
    en_l[5]  = 1'b1;
    en_l[3]  = 1'b1;
    nx(4);
    cnt3 = 0;
    cnt5 = 0;
    repeat (10) begin
      nx(1);
      if (pulse_l[3]) cnt3++;
      if (pulse_l[5]) cnt5++;
    end
    chk("p0_const_high", 3, cnt3, 10);
    chk("pw4_const_high", 5, cnt5, 10);
    en_l[5] = 1'b0;
    en_l[3] = 1'b0;
    nx(1);

    // Lane 5 one-shot restarted while its stretch is still running.
    mode_l[5]  = 1'b1;
    en_l[5]    = 1'b1;
    start_l[5] = 1'b1;
    nx(1);
    start_l[5] = 1'b0;
    nx(2);
    chk("os_str_busy", 5, int'(busy_l[5]), 0);
    chk("os_str_pulse", 5, int'(pulse_l[5]), 1);
    start_l[5] = 1'b1;
    nx(1);
    start_l[5] = 1'b0;
    chk("os_restart_busy", 5, int'(busy_l[5]), 1);
    chk("os_restart_pulse", 5, int'(pulse_l[5]), 1);
    nx(6);
    en_l[5]   = 1'b0;
    mode_l[5] = 1'b0;
    nx(1);

    // Four channels P=0..3, async reset between edges, restart on resampled en.
    for (int l = 0; l < 4; l++) per_l[l] = 27'(l);
    en_l[3:0] = 4'hF;
    nx(7);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_pulse", -1, int'(pulse_l), 0);
    chk("async_rst_busy", -1, int'(busy_l), 0);
    nx(2);
    rst_n = 1'b1;
    nx(1);
    chk("restart_busy", -1, int'(busy_l[3:0]), 15);
    chk("restart_pulse", -1, int'(pulse_l[3:0]), 0);
    nx(1);
    chk("restart_p0_fire", 0, int'(pulse_l[0]), 1);
    nx(8);
    en_l = '0;
    nx(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
